// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM/IO access arbiter.
// The RAM read decoder reuses the state encodings and IO address constants defined here.
package ram_arb_pkg;
  localparam int ARB_AW        = 8;
  localparam int ARB_DW        = 16;
  localparam int ARB_RAM_WORDS = 8;
  localparam logic [7:0] ARB_IO_IN_AD  = 8'h41;
  localparam logic [7:0] ARB_IO_OUT_AD = 8'h40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Requester identity; it is also used as the index into the per-requester vectors.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. SEL and LAST use 0 for A and 1 for B.
module rr_arb2 (
  input  logic REQ_A,
  input  logic REQ_B,
  input  logic LAST,
  output logic SEL
);
  // On a tie, the requester that did not win last time gets the grant.
  assign SEL = (REQ_A & REQ_B) ? ~LAST : REQ_B;
endmodule

// File: rtl/ram_arb.sv
// Serialises requester A (CPU) and B (loader) onto the shared RAM/IO port.
// Flow: IDLE picks a winner and latches its access, ACC grants it, and WAIT collects read data.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int AW        = ARB_AW,
  parameter int DW        = ARB_DW,
  parameter int RAM_WORDS = ARB_RAM_WORDS,
  parameter logic [AW-1:0] IO_IN_AD  = ARB_IO_IN_AD,
  parameter logic [AW-1:0] IO_OUT_AD = ARB_IO_OUT_AD
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          A_REQ,
  input  logic          A_WE,
  input  logic [AW-1:0] A_AD,
  input  logic [DW-1:0] A_WD,
  output logic          A_GNT,
  output logic [DW-1:0] A_RD,
  output logic          A_RVALID,
  output logic          A_ERR,
  input  logic          B_REQ,
  input  logic          B_WE,
  input  logic [AW-1:0] B_AD,
  input  logic [DW-1:0] B_WD,
  output logic          B_GNT,
  output logic [DW-1:0] B_RD,
  output logic          B_RVALID,
  output logic          B_ERR,
  output logic [AW-1:0] RAM_AD,
  output logic [DW-1:0] RAM_WD,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_RD,
  output logic          IO_OUT_WE
);
  localparam logic [AW-1:0] RAM_LIM = AW'(RAM_WORDS);

  state_t r_state, w_state_nxt;
  logic r_last, r_sel, r_pend_rd, r_pend_erd;
  logic [AW-1:0] r_ram_ad;
  logic [DW-1:0] r_ram_wd;
  logic r_ram_we, r_io_we;
  logic [1:0] r_gnt, r_err, r_rvalid;
  logic [1:0][DW-1:0] r_rd;

  logic w_sel, w_any, w_we, w_in_ram, w_wr_ok, w_rd_ok;
  logic [AW-1:0] w_ad;
  logic [DW-1:0] w_wd;

  rr_arb2 u_rr (.REQ_A(A_REQ), .REQ_B(B_REQ), .LAST(r_last), .SEL(w_sel));

  assign w_any    = A_REQ | B_REQ;
  assign w_we     = w_sel ? B_WE : A_WE;
  assign w_ad     = w_sel ? B_AD : A_AD;
  assign w_wd     = w_sel ? B_WD : A_WD;
  assign w_in_ram = w_ad < RAM_LIM;
  assign w_wr_ok  = w_we & (w_in_ram | (w_ad == IO_OUT_AD));
  assign w_rd_ok  = ~w_we & (w_in_ram | (w_ad == IO_IN_AD));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = ACC;
      ACC:     w_state_nxt = r_pend_rd ? WAIT : IDLE;
      WAIT:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Every output is registered, so pulses are set one edge ahead of the cycle they belong to.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_last     <= SEL_B;
      r_sel      <= SEL_A;
      r_pend_rd  <= 1'b0;
      r_pend_erd <= 1'b0;
      r_ram_ad   <= '0;
      r_ram_wd   <= '0;
      r_ram_we   <= 1'b0;
      r_io_we    <= 1'b0;
      r_gnt      <= '0;
      r_err      <= '0;
      r_rvalid   <= '0;
      r_rd       <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_io_we  <= 1'b0;
      r_gnt    <= '0;
      r_err    <= '0;
      r_rvalid <= '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_sel <= w_sel;
          if (A_REQ & B_REQ) r_last <= w_sel;
          r_ram_ad     <= w_ad;
          r_ram_wd     <= w_wd;
          r_gnt[w_sel] <= 1'b1;
          r_err[w_sel] <= ~(w_wr_ok | w_rd_ok);
          r_ram_we     <= w_wr_ok & w_in_ram;
          r_io_we      <= w_wr_ok & ~w_in_ram;
          r_pend_rd    <= w_rd_ok;
          r_pend_erd   <= ~w_we & ~w_rd_ok;
        end
        ACC: if (r_pend_erd) begin
          r_rd[r_sel]     <= '0;
          r_rvalid[r_sel] <= 1'b1;
        end
        WAIT: begin
          r_rd[r_sel]     <= RAM_RD;
          r_rvalid[r_sel] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign A_GNT     = r_gnt[SEL_A];
  assign B_GNT     = r_gnt[SEL_B];
  assign A_ERR     = r_err[SEL_A];
  assign B_ERR     = r_err[SEL_B];
  assign A_RVALID  = r_rvalid[SEL_A];
  assign B_RVALID  = r_rvalid[SEL_B];
  assign A_RD      = r_rd[SEL_A];
  assign B_RD      = r_rd[SEL_B];
  assign RAM_AD    = r_ram_ad;
  assign RAM_WD    = r_ram_wd;
  assign RAM_WE    = r_ram_we;
  assign IO_OUT_WE = r_io_we;
endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb. A small registered RAM/IO model drives RAM_RD.
module tb_ram_arb;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        A_REQ, A_WE, B_REQ, B_WE;
  logic [7:0]  A_AD, B_AD, RAM_AD;
  logic [15:0] A_WD, B_WD, A_RD, B_RD, RAM_WD, RAM_RD;
  logic        A_GNT, A_RVALID, A_ERR, B_GNT, B_RVALID, B_ERR, RAM_WE, IO_OUT_WE;
  logic [15:0] mem [8];
  logic [15:0] io_in;
  int checks = 0;
  int errors = 0;

  // Flag order: A_GNT A_ERR A_RVALID B_GNT B_ERR B_RVALID RAM_WE IO_OUT_WE
  wire [7:0] st = {A_GNT, A_ERR, A_RVALID, B_GNT, B_ERR, B_RVALID, RAM_WE, IO_OUT_WE};

  ram_arb dut (
    .CLK(CLK), .RESET(RESET),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_AD(A_AD), .A_WD(A_WD),
    .A_GNT(A_GNT), .A_RD(A_RD), .A_RVALID(A_RVALID), .A_ERR(A_ERR),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_AD(B_AD), .B_WD(B_WD),
    .B_GNT(B_GNT), .B_RD(B_RD), .B_RVALID(B_RVALID), .B_ERR(B_ERR),
    .RAM_AD(RAM_AD), .RAM_WD(RAM_WD), .RAM_WE(RAM_WE), .RAM_RD(RAM_RD),
    .IO_OUT_WE(IO_OUT_WE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RAM_WE && RAM_AD < 8'd8) mem[RAM_AD[2:0]] <= RAM_WD;
    if (RAM_AD == 8'h41)    RAM_RD <= io_in;
    else if (RAM_AD < 8'd8) RAM_RD <= mem[RAM_AD[2:0]];
    else                    RAM_RD <= 16'hDEAD;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick();
    checks++;
    if (st !== 8'h00 || RAM_AD !== 8'h00 || RAM_WD !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got st=%b ad=%h wd=%h want 0", st, RAM_AD, RAM_WD);
    end
    RESET = 1'b0;
    tick();
    A_REQ = 1'b1; A_WE = 1'b0; A_AD = 8'd3;
    tick();
    checks++;
    if (st !== 8'b1000_0000) begin errors++; $display("FAIL abort_gnt got %b want 10000000", st); end
    A_REQ = 1'b0;
    tick();
    RESET = 1'b1;
    #1;
    checks++;
    if (st !== 8'h00 || RAM_AD !== 8'h00 || A_RD !== 16'h0) begin
      errors++;
      $display("FAIL abort_outputs got st=%b ad=%h rd=%h want 0", st, RAM_AD, A_RD);
    end
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (A_RVALID !== 1'b0) begin errors++; $display("FAIL abort_no_rvalid cyc %0d got %b want 0", i, A_RVALID); end
    end
  endtask

  task automatic test_a_write;
    A_REQ = 1'b1; A_WE = 1'b1; A_AD = 8'd3; A_WD = 16'h1234;
    tick();
    checks++;
    if (st !== 8'b1000_0010 || RAM_AD !== 8'd3 || RAM_WD !== 16'h1234) begin
      errors++;
      $display("FAIL wr_acc got st=%b ad=%h wd=%h want 10000010 03 1234", st, RAM_AD, RAM_WD);
    end
    A_REQ = 1'b0;
    tick();
    checks++;
    if (st !== 8'h00 || RAM_AD !== 8'd3) begin errors++; $display("FAIL wr_after got st=%b ad=%h want 0 03", st, RAM_AD); end
    A_REQ = 1'b1; A_WE = 1'b0; A_AD = 8'd3;
    tick();
    checks++;
    if (st !== 8'b1000_0000) begin errors++; $display("FAIL rd_gnt got %b want 10000000", st); end
    A_REQ = 1'b0;
    tick();
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL rd_wait got %b want 0", st); end
    tick();
    checks++;
    if (st !== 8'b0010_0000 || A_RD !== 16'h1234) begin
      errors++;
      $display("FAIL rd_data got st=%b rd=%h want 00100000 1234", st, A_RD);
    end
    tick();
    checks++;
    if (A_RVALID !== 1'b0 || A_RD !== 16'h1234) begin
      errors++;
      $display("FAIL rd_hold got rv=%b rd=%h want 0 1234", A_RVALID, A_RD);
    end
  endtask

  task automatic test_back_to_back;
    A_REQ = 1'b1; A_WE = 1'b1; A_AD = 8'd5; A_WD = 16'h5555;
    tick();
    checks++;
    if (st !== 8'b1000_0010 || RAM_AD !== 8'd5) begin errors++; $display("FAIL b2b_w1 got st=%b ad=%h want 10000010 05", st, RAM_AD); end
    A_AD = 8'd6; A_WD = 16'h6666;
    tick();
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL b2b_gap got %b want 0", st); end
    tick();
    checks++;
    if (st !== 8'b1000_0010 || RAM_AD !== 8'd6 || RAM_WD !== 16'h6666) begin
      errors++;
      $display("FAIL b2b_w2 got st=%b ad=%h wd=%h want 10000010 06 6666", st, RAM_AD, RAM_WD);
    end
    A_REQ = 1'b0;
    tick();
  endtask

  task automatic test_io;
    B_REQ = 1'b1; B_WE = 1'b1; B_AD = 8'h40; B_WD = 16'h00FF;
    tick();
    checks++;
    if (st !== 8'b0001_0001 || RAM_WD !== 16'h00FF) begin
      errors++;
      $display("FAIL io_wr got st=%b wd=%h want 00010001 00ff", st, RAM_WD);
    end
    B_REQ = 1'b0;
    tick();
    io_in = 16'hBEEF;
    B_REQ = 1'b1; B_WE = 1'b0; B_AD = 8'h41;
    tick();
    checks++;
    if (st !== 8'b0001_0000) begin errors++; $display("FAIL io_rd_gnt got %b want 00010000", st); end
    B_REQ = 1'b0;
    tick();
    tick();
    checks++;
    if (st !== 8'b0000_0100 || B_RD !== 16'hBEEF) begin
      errors++;
      $display("FAIL io_rd_data got st=%b rd=%h want 00000100 beef", st, B_RD);
    end
    tick();
  endtask

  task automatic test_errors;
    A_REQ = 1'b1; A_WE = 1'b0; A_AD = 8'h10;
    tick();
    checks++;
    if (st !== 8'b1100_0000) begin errors++; $display("FAIL err_rd got %b want 11000000", st); end
    A_REQ = 1'b0;
    tick();
    checks++;
    if (st !== 8'b0010_0000 || A_RD !== 16'h0) begin
      errors++;
      $display("FAIL err_rd_resp got st=%b rd=%h want 00100000 0000", st, A_RD);
    end
    A_REQ = 1'b1; A_WE = 1'b1; A_AD = 8'h41; A_WD = 16'hAAAA;
    tick();
    checks++;
    if (st !== 8'b1100_0000) begin errors++; $display("FAIL err_wr got %b want 11000000", st); end
    A_REQ = 1'b0;
    tick();
    checks++;
    if (st !== 8'h00) begin errors++; $display("FAIL err_wr_after got %b want 0", st); end
    A_REQ = 1'b1; A_WE = 1'b1; A_AD = 8'h48; A_WD = 16'hBBBB;
    tick();
    checks++;
    if (st !== 8'b1100_0000) begin errors++; $display("FAIL err_alias got %b want 11000000", st); end
    A_REQ = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    logic [15:0] exp_rd;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    A_REQ = 1'b1; A_WE = 1'b0; A_AD = 8'd3;
    B_REQ = 1'b1; B_WE = 1'b0; B_AD = 8'd5;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ((k % 2 == 0 && st !== 8'b1000_0000) || (k % 2 == 1 && st !== 8'b0001_0000)) begin
        errors++;
        $display("FAIL cont_gnt %0d got %b want %s", k, st, (k % 2 == 0) ? "A" : "B");
      end
      if (k == 3) begin A_REQ = 1'b0; B_REQ = 1'b0; end
      tick();
      tick();
      exp_rd = (k % 2 == 0) ? 16'h1234 : 16'h5555;
      checks++;
      if ((k % 2 == 0 && (st !== 8'b0010_0000 || A_RD !== exp_rd)) ||
          (k % 2 == 1 && (st !== 8'b0000_0100 || B_RD !== exp_rd))) begin
        errors++;
        $display("FAIL cont_rv %0d got st=%b a=%h b=%h want %h", k, st, A_RD, B_RD, exp_rd);
      end
    end
  endtask

  initial begin
    RESET = 1'b0;
    A_REQ = 1'b0; A_WE = 1'b0; A_AD = '0; A_WD = '0;
    B_REQ = 1'b0; B_WE = 1'b0; B_AD = '0; B_WD = '0;
    io_in = 16'h0;
    #2;
    test_reset();
    test_a_write();
    test_back_to_back();
    test_io();
    test_errors();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
